pingpong_buf_ctrl: RTL and testbench

Two-bank ping-pong byte buffer that sits between the SPI slave's receive side and its transmit side.
- The write port takes bytes and a frame-finish strobe from the SPI slave.
- The read port gives a completed frame back to the SPI slave's MISO path.
- It tracks the state of each bank and gives the slave its ready flags.
- Frames are read out in the same order they were written.

---
 rtl/pingpong_buf_ctrl_pkg.sv | 17 +
 rtl/pingpong_buf_ctrl_if.sv | 40 ++++
 rtl/pingpong_buf_ctrl_bank.sv | 23 ++
 rtl/pingpong_buf_ctrl.sv | 131 +++++++++++++
 tb/tb_pingpong_buf_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/pingpong_buf_ctrl_pkg.sv
// Shared types and sizing for the ping-pong SPI frame buffer.
package pingpong_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    localparam int AW_DEF = 7;
    localparam int DW_DEF = 8;

    function automatic int unsigned depth(input int aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/pingpong_buf_ctrl_if.sv
// SPI-slave <-> ping-pong buffer bus; master = SPI slave, slave = buffer.
// Stats outputs exist only when PINGPONG_STATS_EN is defined.
interface pingpong_buf_ctrl_if #(parameter int AW = 7, parameter int DW = 8);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_finish;
    logic          wr_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic          rd_finish;
    logic [AW:0]   rd_len;
    logic          overflow;
`ifdef PINGPONG_STATS_EN
    logic [15:0]   frames_in;
    logic [15:0]   frames_out;
    logic [15:0]   bytes_dropped;

    modport master (
        output wr_en, wr_addr, wr_data, wr_finish, rd_addr, rd_finish,
        input  wr_ready, rd_data, rd_ready, rd_len, overflow,
               frames_in, frames_out, bytes_dropped
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, wr_finish, rd_addr, rd_finish,
        output wr_ready, rd_data, rd_ready, rd_len, overflow,
               frames_in, frames_out, bytes_dropped
    );
`else
    modport master (
        output wr_en, wr_addr, wr_data, wr_finish, rd_addr, rd_finish,
        input  wr_ready, rd_data, rd_ready, rd_len, overflow
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, wr_finish, rd_addr, rd_finish,
        output wr_ready, rd_data, rd_ready, rd_len, overflow
    );
`endif
endinterface

// File: rtl/pingpong_buf_ctrl_bank.sv
// One DEPTH x DW buffer bank: synchronous write, synchronous read.
module pingpong_bank
    import pingpong_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    localparam int unsigned DEPTH = depth(AW);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong frame buffer controller: bank state tracking, lengths, ready flags.
// Optional PINGPONG_STATS_EN adds saturating frame/drop counters.
//   state   | meaning
//   EMPTY   | bank free, not yet handed to the writer
//   FILLING | bank open for writes (only ever the wsel bank)
//   FULL    | completed frame waiting to be read
module pingpong_buf_ctrl
    import pingpong_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    pingpong_buf_ctrl_if.slave bus
);
    localparam int unsigned   DEPTH   = depth(AW);
    localparam logic [AW:0]   DEPTH_L = DEPTH[AW:0];

    bank_state_t   bank   [2];
    bank_state_t   bank_n [2];
    logic          wsel, wsel_n, rsel, rsel_n;
    logic [AW:0]   wcnt, wcnt_n, wcnt_inc;
    logic [AW:0]   len   [2];
    logic [AW:0]   len_n [2];
    logic          overflow, overflow_n;
    logic          wr_acc, drop, rd_acc, fin_acc;
    logic          rd_valid_q, rd_bank_q;
    logic [DW-1:0] q [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pingpong_bank #(.AW(AW), .DW(DW)) u_bank (
            .clk   (clk),
            .we    (wr_acc && (wsel == 1'(b))),
            .waddr (bus.wr_addr),
            .wdata (bus.wr_data),
            .raddr (bus.rd_addr),
            .rdata (q[b])
        );
    end

    assign bus.wr_ready = (bank[wsel] == FILLING);
    assign bus.rd_ready = (bank[rsel] == FULL);
    assign bus.rd_len   = bus.rd_ready ? len[rsel] : '0;
    assign bus.overflow = overflow;
    assign bus.rd_data  = rd_valid_q ? q[rd_bank_q] : '0;

    assign wr_acc   = bus.wr_en && bus.wr_ready;
    assign drop     = bus.wr_en && !bus.wr_ready;
    assign rd_acc   = bus.rd_finish && bus.rd_ready;
    assign wcnt_inc = (wr_acc && wcnt != DEPTH_L) ? wcnt + 1'b1 : wcnt;
    // a byte landing in the finish cycle is part of the frame
    assign fin_acc  = bus.wr_finish && bus.wr_ready && (wcnt_inc != '0);

    always_comb begin
        bank_n[0]  = bank[0];
        bank_n[1]  = bank[1];
        len_n[0]   = len[0];
        len_n[1]   = len[1];
        wsel_n     = wsel;
        rsel_n     = rsel;
        wcnt_n     = wcnt_inc;
        overflow_n = overflow | drop;

        // read release first so a freed bank is visible to the write swap
        if (rd_acc) begin
            bank_n[rsel] = EMPTY;
            rsel_n       = ~rsel;
            if (bank[wsel] != FILLING) begin
                bank_n[rsel] = FILLING;
                wsel_n       = rsel;
            end
        end

        if (fin_acc) begin
            bank_n[wsel] = FULL;
            len_n[wsel]  = wcnt_inc;
            wcnt_n       = '0;
            if (bank_n[~wsel] == EMPTY) begin
                bank_n[~wsel] = FILLING;
                wsel_n        = ~wsel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank[0]    <= FILLING;
            bank[1]    <= EMPTY;
            len[0]     <= '0;
            len[1]     <= '0;
            wsel       <= 1'b0;
            rsel       <= 1'b0;
            wcnt       <= '0;
            overflow   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_bank_q  <= 1'b0;
        end else begin
            bank[0]    <= bank_n[0];
            bank[1]    <= bank_n[1];
            len[0]     <= len_n[0];
            len[1]     <= len_n[1];
            wsel       <= wsel_n;
            rsel       <= rsel_n;
            wcnt       <= wcnt_n;
            overflow   <= overflow_n;
            rd_valid_q <= bus.rd_ready && ({1'b0, bus.rd_addr} < len[rsel]);
            rd_bank_q  <= rsel;
        end
    end

`ifdef PINGPONG_STATS_EN
    logic [15:0] frames_in, frames_out, bytes_dropped;

    assign bus.frames_in     = frames_in;
    assign bus.frames_out    = frames_out;
    assign bus.bytes_dropped = bytes_dropped;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_in     <= '0;
            frames_out    <= '0;
            bytes_dropped <= '0;
        end else begin
            if (fin_acc && frames_in != 16'hFFFF)     frames_in     <= frames_in + 1'b1;
            if (rd_acc && frames_out != 16'hFFFF)     frames_out    <= frames_out + 1'b1;
            if (drop && bytes_dropped != 16'hFFFF)    bytes_dropped <= bytes_dropped + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Directed bench for pingpong_buf_ctrl with hand-computed expectations.
module tb_pingpong_buf_ctrl;
    import pingpong_pkg::*;

    localparam int AW = 7;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;
    logic [DW-1:0] d;

    always #5 clk = ~clk;

    pingpong_buf_ctrl_if #(.AW(AW), .DW(DW)) bif ();

    pingpong_buf_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bif.wr_en     = 1'b0;
        bif.wr_addr   = '0;
        bif.wr_data   = '0;
        bif.wr_finish = 1'b0;
        bif.rd_addr   = '0;
        bif.rd_finish = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wr_byte(input int a, input int v);
        bif.wr_addr = AW'(a);
        bif.wr_data = DW'(v);
        bif.wr_en   = 1'b1;
        cyc();
        bif.wr_en   = 1'b0;
    endtask

    task automatic wfin();
        bif.wr_finish = 1'b1;
        cyc();
        bif.wr_finish = 1'b0;
    endtask

    task automatic rfin();
        bif.rd_finish = 1'b1;
        cyc();
        bif.rd_finish = 1'b0;
    endtask

    task automatic rd_at(input int a, output logic [DW-1:0] v);
        bif.rd_addr = AW'(a);
        cyc();
        v = bif.rd_data;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        do_reset();

        chk("rst_wr_ready", int'(bif.wr_ready), 1);
        chk("rst_rd_ready", int'(bif.rd_ready), 0);
        chk("rst_rd_len",   int'(bif.rd_len),   0);
        chk("rst_rd_data",  int'(bif.rd_data),  0);
        chk("rst_overflow", int'(bif.overflow), 0);

        // 1: single frame, read back
        wr_byte(0, 8'h11);
        wr_byte(1, 8'h22);
        wr_byte(2, 8'h33);
        wfin();
        chk("t1_rd_ready", int'(bif.rd_ready), 1);
        chk("t1_rd_len",   int'(bif.rd_len),   3);
        chk("t1_wsel",     int'(dut.wsel),     1);
        chk("t1_wr_ready", int'(bif.wr_ready), 1);
        rd_at(1, d);
        chk("t1_rd_a1", int'(d), 8'h22);
        rd_at(5, d);
        chk("t1_rd_a5", int'(d), 8'h00);

        // 2: two frames fill both banks, drop, release
        do_reset();
        wr_byte(0, 8'hA0);
        wr_byte(1, 8'hA1);
        wfin();
        for (int i = 0; i < 4; i++) wr_byte(i, 8'hB0 + i);
        wfin();
        chk("t2_wr_ready_full", int'(bif.wr_ready), 0);
        chk("t2_rd_len_first",  int'(bif.rd_len),   2);
        wr_byte(0, 8'hEE);
        chk("t2_overflow", int'(bif.overflow), 1);
        rfin();
        chk("t2_rd_len_second", int'(bif.rd_len),   4);
        chk("t2_wr_ready_back", int'(bif.wr_ready), 1);
        chk("t2_wsel",          int'(dut.wsel),     0);
        rd_at(3, d);
        chk("t2_rd_a3", int'(d), 8'hB3);
        for (int i = 0; i < 3; i++) wr_byte(i, 8'hC0 + i);
        wfin();
        chk("t2_wr_ready_full2", int'(bif.wr_ready), 0);
        chk("t2_rd_len_still",   int'(bif.rd_len),   4);

        // 3: FULL/FULL, wr_finish and rd_finish together
        bif.wr_finish = 1'b1;
        bif.rd_finish = 1'b1;
        cyc();
        bif.wr_finish = 1'b0;
        bif.rd_finish = 1'b0;
        chk("t3_rd_len",   int'(bif.rd_len),   3);
        chk("t3_wr_ready", int'(bif.wr_ready), 1);
        chk("t3_wsel",     int'(dut.wsel),     1);
        chk("t3_overflow", int'(bif.overflow), 1);
        rd_at(2, d);
        chk("t3_rd_a2", int'(d), 8'hC2);

        // 4: bank1 FULL, bank0 FILLING, last byte + wr_finish + rd_finish
        rfin();
        chk("t4_rd_ready_gap", int'(bif.rd_ready), 0);
        wr_byte(0, 8'hD0);
        wr_byte(1, 8'hD1);
        wfin();
        chk("t4_pre_rd_len", int'(bif.rd_len), 2);
        chk("t4_pre_wsel",   int'(dut.wsel),   0);
        wr_byte(0, 8'hE0);
        bif.wr_addr   = 7'd1;
        bif.wr_data   = 8'hE1;
        bif.wr_en     = 1'b1;
        bif.wr_finish = 1'b1;
        bif.rd_finish = 1'b1;
        cyc();
        clear_inputs();
        chk("t4_rd_ready", int'(bif.rd_ready), 1);
        chk("t4_rd_len",   int'(bif.rd_len),   2);
        chk("t4_wsel",     int'(dut.wsel),     1);
        chk("t4_rsel",     int'(dut.rsel),     0);
        chk("t4_wr_ready", int'(bif.wr_ready), 1);
        rd_at(1, d);
        chk("t4_rd_a1", int'(d), 8'hE1);

        // 5: empty finish ignored; 130-byte frame saturates and wraps
        do_reset();
        wfin();
        chk("t5_empty_rd_ready", int'(bif.rd_ready), 0);
        chk("t5_empty_wr_ready", int'(bif.wr_ready), 1);
        chk("t5_empty_wsel",     int'(dut.wsel),     0);
        for (int i = 0; i < 130; i++) wr_byte(i % 128, i & 8'hFF);
        wfin();
        chk("t5_rd_len_sat", int'(bif.rd_len), 128);
        rd_at(0, d);
        chk("t5_rd_a0", int'(d), 8'h80);
        rd_at(1, d);
        chk("t5_rd_a1", int'(d), 8'h81);
        rd_at(127, d);
        chk("t5_rd_a127", int'(d), 8'h7F);
`ifdef PINGPONG_STATS_EN
        chk("t5_frames_in", int'(bif.frames_in), 1);
`endif

        // 6: asynchronous reset mid-frame
        for (int i = 0; i < 5; i++) wr_byte(i, 8'h50 + i);
        chk("t6_pre_rd_data", int'(bif.rd_data), 8'h7F);
        #3 rst = 1'b1;
        #1;
        chk("t6_wr_ready", int'(bif.wr_ready), 1);
        chk("t6_rd_ready", int'(bif.rd_ready), 0);
        chk("t6_rd_len",   int'(bif.rd_len),   0);
        chk("t6_rd_data",  int'(bif.rd_data),  0);
        chk("t6_overflow", int'(bif.overflow), 0);
        chk("t6_wsel",     int'(dut.wsel),     0);
`ifdef PINGPONG_STATS_EN
        chk("t6_frames_in",     int'(bif.frames_in),     0);
        chk("t6_frames_out",    int'(bif.frames_out),    0);
        chk("t6_bytes_dropped", int'(bif.bytes_dropped), 0);
`endif
        clear_inputs();
        cyc();
        rst = 1'b0;
        wr_byte(0, 8'h99);
        wfin();
        chk("t6_post_rd_len", int'(bif.rd_len), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
